ahbslv_wbmas_bridge: RTL and testbench

AHBSLV_WBMAS_BRIDGE -- requirements
Module: ahbslv_wbmas_bridge

---
 rtl/ahbslv_wbmas_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_ahbslv_wbmas_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbslv_wbmas_bridge.sv
// AHB-Lite slave to classic Wishbone master bridge: one single Wishbone cycle per AHB beat.
// Optional WB_WAIT timeout is enabled by defining AHBSLV_WBMAS_TIMEOUT_EN.
module ahbslv_wbmas_bridge #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  // AHB slave side
  input  logic              hsel,
  input  logic [AWIDTH-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DWIDTH-1:0] hwdata,
  input  logic              hready,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [DWIDTH-1:0] hrdata,
  // Wishbone master side
  output logic [AWIDTH-1:0] adr_o,
  output logic [DWIDTH-1:0] dat_o,
  output logic [3:0]        sel_o,
  output logic              we_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic [DWIDTH-1:0] dat_i,
  input  logic              ack_i,
  input  logic              err_i
);

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StWbWait,
    StDone,
    StErr1,
    StErr2
  } state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   adr_q, adr_d;
  logic [DWIDTH-1:0]   dat_q, dat_d;
  logic [DWIDTH-1:0]   hrdata_q, hrdata_d;
  logic [3:0]          sel_q, sel_d;
  logic                we_q, we_d;
  logic                cyc_q, cyc_d;
  logic                accept;

`ifdef AHBSLV_WBMAS_TIMEOUT_EN
  // Fires on the edge that would bring the count to 255, i.e. after 255 WB_WAIT cycles.
  localparam logic [7:0] TmoLast = 8'd254;
  logic [7:0] tmo_q, tmo_d;
`endif

  // hburst is ignored: every beat becomes its own Wishbone cycle.
  logic unused_inputs;
  assign unused_inputs = ^{hburst, htrans[0]};

  assign accept = hsel & hready & htrans[1];

  function automatic logic [3:0] sel_decode(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] sel;
    case (size)
      3'b000:  sel = 4'b0001 << lsb;
      3'b001:  sel = lsb[1] ? 4'b1100 : 4'b0011;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    hrdata_d   = hrdata_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    hready_out = 1'b1;
    hresp      = RespOkay;
`ifdef AHBSLV_WBMAS_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif

    case (state_q)
      StIdle, StDone, StErr2: begin
        if (state_q == StErr2) begin
          hresp = RespError;
        end
        if (accept) begin
          adr_d = haddr;
          sel_d = sel_decode(hsize, haddr[1:0]);
          if (hwrite) begin
            state_d = StWdata;
          end else begin
            state_d = StWbWait;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
`ifdef AHBSLV_WBMAS_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end else begin
          state_d = StIdle;
        end
      end

      StWdata: begin
        hready_out = 1'b0;
        dat_d      = hwdata;
        cyc_d      = 1'b1;
        we_d       = 1'b1;
        state_d    = StWbWait;
`ifdef AHBSLV_WBMAS_TIMEOUT_EN
        tmo_d      = '0;
`endif
      end

      StWbWait: begin
        hready_out = 1'b0;
`ifdef AHBSLV_WBMAS_TIMEOUT_EN
        tmo_d      = tmo_q + 8'd1;
`endif
        // err_i takes priority over a simultaneous ack_i.
        if (err_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StErr1;
        end else if (ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) begin
            hrdata_d = dat_i;
          end
          state_d = StDone;
        end
`ifdef AHBSLV_WBMAS_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StErr1;
        end
`endif
      end

      StErr1: begin
        hready_out = 1'b0;
        hresp      = RespError;
        state_d    = StErr2;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= StIdle;
      adr_q    <= '0;
      dat_q    <= '0;
      hrdata_q <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      hrdata_q <= hrdata_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
    end
  end

`ifdef AHBSLV_WBMAS_TIMEOUT_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign adr_o  = adr_q;
  assign dat_o  = dat_q;
  assign sel_o  = sel_q;
  assign we_o   = we_q;
  assign cyc_o  = cyc_q;
  assign stb_o  = cyc_q;
  assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahbslv_wbmas_bridge.sv
// Directed self-checking bench for ahbslv_wbmas_bridge.
module tb_ahbslv_wbmas_bridge;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  ahbslv_wbmas_bridge #(
    .AWIDTH(32),
    .DWIDTH(32)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hready    (hready),
    .hready_out(hready_out),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .sel_o     (sel_o),
    .we_o      (we_o),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .dat_i     (dat_i),
    .ack_i     (ack_i),
    .err_i     (err_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  // Single read with ack in the first WB_WAIT cycle.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [2:0] sz,
                         input logic [3:0] esel, input logic [31:0] d);
    addr_phase(1'b0, a, sz);
    tick();
    bus_idle();
    check_eq({tag, "_cyc"}, {31'd0, cyc_o}, 32'd1);
    check_eq({tag, "_sel"}, {28'd0, sel_o}, {28'd0, esel});
    check_eq({tag, "_adr"}, adr_o, a);
    check_eq({tag, "_wait"}, {31'd0, hready_out}, 32'd0);
    ack_i = 1'b1;
    dat_i = d;
    tick();
    ack_i = 1'b0;
    check_eq({tag, "_rdata"}, hrdata, d);
    check_eq({tag, "_done_rdy"}, {31'd0, hready_out}, 32'd1);
    check_eq({tag, "_done_cyc"}, {31'd0, cyc_o}, 32'd0);
    tick();
  endtask

  initial begin
    hresetn = 1'b0;
    hsel    = 1'b0;
    haddr   = '0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    hsize   = 3'b010;
    hburst  = 3'b000;
    hwdata  = '0;
    hready  = 1'b1;
    dat_i   = '0;
    ack_i   = 1'b0;
    err_i   = 1'b0;

    #12;
    check_eq("rst_rdy", {31'd0, hready_out}, 32'd1);
    check_eq("rst_resp", {30'd0, hresp}, 32'd0);
    check_eq("rst_cyc", {31'd0, cyc_o}, 32'd0);
    check_eq("rst_we", {31'd0, we_o}, 32'd0);
    check_eq("rst_rdata", hrdata, 32'd0);
    check_eq("rst_sel", {28'd0, sel_o}, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    tick();

    // Basic word read
    do_read("rd_word", 32'h100, 3'b010, 4'hF, 32'hDEADBEEF);
    check_eq("rd_word_resp", {30'd0, hresp}, 32'd0);

    // Byte / halfword lane decode on reads
    do_read("rd_b1", 32'h1001, 3'b000, 4'b0010, 32'h01020304);
    do_read("rd_h2", 32'h1002, 3'b001, 4'b1100, 32'h12345678);
    do_read("rd_h0", 32'h1000, 3'b001, 4'b0011, 32'h9ABCDEF0);

    // Non-accepted transfers: hsel low, BUSY, hready low
    addr_phase(1'b0, 32'h600, 3'b010);
    hsel = 1'b0;
    tick();
    check_eq("nosel_cyc", {31'd0, cyc_o}, 32'd0);
    check_eq("nosel_rdy", {31'd0, hready_out}, 32'd1);
    addr_phase(1'b0, 32'h600, 3'b010);
    htrans = 2'b01;
    tick();
    check_eq("busy_cyc", {31'd0, cyc_o}, 32'd0);
    addr_phase(1'b0, 32'h600, 3'b010);
    hready = 1'b0;
    tick();
    hready = 1'b1;
    bus_idle();
    check_eq("nordy_cyc", {31'd0, cyc_o}, 32'd0);

    // ack outside WB_WAIT is ignored
    ack_i = 1'b1;
    dat_i = 32'h55AA55AA;
    tick();
    ack_i = 1'b0;
    check_eq("stray_ack_rdata", hrdata, 32'h9ABCDEF0);
    check_eq("stray_ack_cyc", {31'd0, cyc_o}, 32'd0);

    // Byte write, ack after three WB_WAIT cycles
    addr_phase(1'b1, 32'h203, 3'b000);
    tick();
    bus_idle();
    check_eq("wr_wdata_rdy", {31'd0, hready_out}, 32'd0);
    check_eq("wr_wdata_cyc", {31'd0, cyc_o}, 32'd0);
    hwdata = 32'h000000A5;
    tick();
    hwdata = 32'hFFFFFFFF;
    check_eq("wr_cyc", {31'd0, cyc_o}, 32'd1);
    check_eq("wr_stb", {31'd0, stb_o}, 32'd1);
    check_eq("wr_we", {31'd0, we_o}, 32'd1);
    check_eq("wr_sel", {28'd0, sel_o}, 32'h8);
    check_eq("wr_adr", adr_o, 32'h203);
    check_eq("wr_dat", dat_o, 32'h000000A5);
    tick();
    tick();
    check_eq("wr_wait3_rdy", {31'd0, hready_out}, 32'd0);
    check_eq("wr_wait3_cyc", {31'd0, cyc_o}, 32'd1);
    ack_i = 1'b1;
    dat_i = 32'h77777777;
    tick();
    ack_i = 1'b0;
    check_eq("wr_done_rdy", {31'd0, hready_out}, 32'd1);
    check_eq("wr_done_cyc", {31'd0, cyc_o}, 32'd0);
    check_eq("wr_keep_rdata", hrdata, 32'h9ABCDEF0);
    tick();
    check_eq("wr_hold_dat", dat_o, 32'h000000A5);

    // Error wins over simultaneous ack; two-cycle ERROR response
    addr_phase(1'b0, 32'h300, 3'b010);
    tick();
    bus_idle();
    err_i = 1'b1;
    ack_i = 1'b1;
    dat_i = 32'h13572468;
    tick();
    err_i = 1'b0;
    ack_i = 1'b0;
    check_eq("err1_rdy", {31'd0, hready_out}, 32'd0);
    check_eq("err1_resp", {30'd0, hresp}, 32'd1);
    check_eq("err1_cyc", {31'd0, cyc_o}, 32'd0);
    check_eq("err1_rdata", hrdata, 32'h9ABCDEF0);
    tick();
    check_eq("err2_rdy", {31'd0, hready_out}, 32'd1);
    check_eq("err2_resp", {30'd0, hresp}, 32'd1);
    tick();
    check_eq("err_idle_resp", {30'd0, hresp}, 32'd0);

    // Pipelined write then read, second address phase during DONE
    addr_phase(1'b1, 32'h400, 3'b010);
    tick();
    bus_idle();
    hwdata = 32'h11223344;
    tick();
    check_eq("pipe_wr_cyc", {31'd0, cyc_o}, 32'd1);
    check_eq("pipe_wr_dat", dat_o, 32'h11223344);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    check_eq("pipe_done_rdy", {31'd0, hready_out}, 32'd1);
    check_eq("pipe_done_cyc", {31'd0, cyc_o}, 32'd0);
    addr_phase(1'b0, 32'h404, 3'b010);
    tick();
    bus_idle();
    check_eq("pipe_rd_cyc", {31'd0, cyc_o}, 32'd1);
    check_eq("pipe_rd_we", {31'd0, we_o}, 32'd0);
    check_eq("pipe_rd_adr", adr_o, 32'h404);
    check_eq("pipe_rd_rdy", {31'd0, hready_out}, 32'd0);
    ack_i = 1'b1;
    dat_i = 32'hCAFEF00D;
    tick();
    ack_i = 1'b0;
    check_eq("pipe_rd_data", hrdata, 32'hCAFEF00D);
    tick();

`ifdef AHBSLV_WBMAS_TIMEOUT_EN
    begin
      int n = 0;
      addr_phase(1'b0, 32'h700, 3'b010);
      tick();
      bus_idle();
      while (cyc_o === 1'b1 && n < 400) begin
        n++;
        tick();
      end
      check_eq("tmo_cycles", n, 32'd255);
      check_eq("tmo_err1_rdy", {31'd0, hready_out}, 32'd0);
      check_eq("tmo_err1_resp", {30'd0, hresp}, 32'd1);
      tick();
      check_eq("tmo_err2_rdy", {31'd0, hready_out}, 32'd1);
      check_eq("tmo_err2_resp", {30'd0, hresp}, 32'd1);
      tick();
    end
`endif

    // Asynchronous reset during WB_WAIT
    addr_phase(1'b0, 32'h500, 3'b010);
    tick();
    bus_idle();
    check_eq("mid_cyc_pre", {31'd0, cyc_o}, 32'd1);
    #2;
    hresetn = 1'b0;
    #1;
    check_eq("mid_rst_cyc", {31'd0, cyc_o}, 32'd0);
    check_eq("mid_rst_stb", {31'd0, stb_o}, 32'd0);
    check_eq("mid_rst_rdy", {31'd0, hready_out}, 32'd1);
    check_eq("mid_rst_resp", {30'd0, hresp}, 32'd0);
    check_eq("mid_rst_rdata", hrdata, 32'd0);
    check_eq("mid_rst_dat", dat_o, 32'd0);
    check_eq("mid_rst_adr", adr_o, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    ack_i = 1'b1;
    dat_i = 32'h24682468;
    tick();
    ack_i = 1'b0;
    check_eq("post_rst_cyc", {31'd0, cyc_o}, 32'd0);
    check_eq("post_rst_rdata", hrdata, 32'd0);
    check_eq("post_rst_rdy", {31'd0, hready_out}, 32'd1);

    do_read("post_rst_rd", 32'h800, 3'b010, 4'hF, 32'h0BADCAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
